// File: rtl/dma_pkg.sv
// Shared DMA definitions: FSM states, AXI response codes
// and the byte-strobe mask helper used by both aligners.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    RESP,
    DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // lanes >= off on the first beat, lanes <= end_lane on the last
  function automatic logic [3:0] strobe_mask(
    input logic       is_first,
    input logic       is_last,
    input logic [1:0] off,
    input logic [1:0] end_lane
  );
    logic [3:0] fm;
    logic [3:0] lm;
    fm = is_first ? (4'hF << off) : 4'hF;
    lm = is_last ? (4'hF >> (2'd3 - end_lane)) : 4'hF;
    return fm & lm;
  endfunction

endpackage

// File: rtl/dma_byte_shifter.sv
// Funnel shifter: moves the packed word stream up by off
// bytes, pulling the low lanes from the previous word.
import dma_pkg::*;

module dma_byte_shifter (
  input  logic [31:0] cur,
  input  logic [31:0] prev,
  input  logic [1:0]  off,
  output logic [31:0] data
);

  always_comb begin
    data = cur;
    unique case (off)
      2'd0: data = cur;
      2'd1: data = {cur[23:0], prev[31:24]};
      2'd2: data = {cur[15:0], prev[31:16]};
      2'd3: data = {cur[7:0],  prev[31:8]};
      default: data = cur;
    endcase
  end

endmodule

// File: rtl/dma_write_aligner.sv
// DMA write aligner: FIFO words -> byte-aligned single-beat
// AXI4-Lite writes with strobes, one transaction in flight.
import dma_pkg::*;

module dma_write_aligner #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic [ADDR_W-1:0] dest_address,
  input  logic [LEN_W-1:0]  length,
  input  logic              fifo_empty,
  input  logic [31:0]       fifo_rd_data,
  output logic              fifo_rd_en,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CW = LEN_W + 1;

  state_t            state;
  logic [1:0]        off;
  logic [1:0]        end_lane;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0]     n_beats;
  logic [CW-1:0]     m_words;
  logic [CW-1:0]     beat;
  logic [31:0]       prev;

  logic [CW-1:0]     n_calc;
  logic [CW-1:0]     m_calc;
  logic [31:0]       cur;
  logic [31:0]       shifted;
  logic [ADDR_W-1:0] beat_addr;
  logic              need_pop;
  logic              fetch_go;
  logic              is_last;
  logic              aw_ok;
  logic              w_ok;

  assign n_calc = (CW'(dest_address[1:0]) + CW'(length)
                   + CW'(3)) >> 2;
  assign m_calc = (CW'(length) + CW'(3)) >> 2;

  assign need_pop = beat < m_words;
  assign is_last  = beat == (n_beats - CW'(1));
  assign cur      = need_pop ? fifo_rd_data : '0;

  assign fifo_rd_en = (state == FETCH) && need_pop
                      && !fifo_empty;
  assign fetch_go   = (state == FETCH)
                      && (!need_pop || !fifo_empty);

  assign beat_addr = base + (ADDR_W'(beat) << 2);

  assign aw_ok = !awvalid || awready;
  assign w_ok  = !wvalid || wready;

  dma_byte_shifter u_shift (
    .cur  (cur),
    .prev (prev),
    .off  (off),
    .data (shifted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      off      <= '0;
      end_lane <= '0;
      base     <= '0;
      n_beats  <= '0;
      m_words  <= '0;
      beat     <= '0;
      prev     <= '0;
      awaddr   <= '0;
      awvalid  <= 1'b0;
      wdata    <= '0;
      wstrb    <= '0;
      wvalid   <= 1'b0;
      bready   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trigger) begin
            off      <= dest_address[1:0];
            end_lane <= dest_address[1:0]
                        + length[1:0] - 2'd1;
            base     <= {dest_address[ADDR_W-1:2], 2'b00};
            n_beats  <= n_calc;
            m_words  <= m_calc;
            beat     <= '0;
            prev     <= '0;
            busy     <= 1'b1;
            error    <= 1'b0;
            state    <= (length == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          if (fetch_go) begin
            wdata   <= shifted;
            wstrb   <= strobe_mask(beat == '0, is_last,
                                   off, end_lane);
            awaddr  <= beat_addr;
            prev    <= cur;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (awready) awvalid <= 1'b0;
          if (wready) wvalid <= 1'b0;
          if (aw_ok && w_ok) begin
            bready <= 1'b1;
            state  <= RESP;
          end
        end
        RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (bresp != RESP_OKAY) error <= 1'b1;
            beat  <= beat + CW'(1);
            state <= is_last ? DONE : FETCH;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_write_aligner.sv
// Scoreboard bench for dma_write_aligner: FIFO and AXI slave
// models, expected beats queued by stimulus, checked by monitor.
module tb_dma_write_aligner;
  import dma_pkg::*;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 5;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              trigger = 1'b0;
  logic [ADDR_W-1:0] dest_address = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              fifo_empty = 1'b1;
  logic [31:0]       fifo_rd_data = '0;
  logic              fifo_rd_en;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp = '0;
  logic              bvalid = 1'b0;
  logic              bready;
  logic              busy;
  logic              done;
  logic              error;

  int checks = 0;
  int errors = 0;

  logic [31:0] fifo_mem [0:63];
  int fifo_cnt = 0;
  int aw_delay = 0;
  int w_delay = 0;
  int err_beat = -1;
  int stall_beat = -1;
  int stall_len = 0;
  beat_t exp_q[$];

  int rd_ptr = 0;
  int stall_left = 0;
  int aw_cnt = 0;
  int w_cnt = 0;
  int b_count = 0;
  bit aw_seen = 0;
  bit w_seen = 0;

  int exp_rd = 0;

  always #5 clk = ~clk;

  assign awready = aw_cnt >= aw_delay;
  assign wready  = w_cnt >= w_delay;

  dma_write_aligner #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .trigger      (trigger),
    .dest_address (dest_address),
    .length       (length),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .awaddr       (awaddr),
    .awvalid      (awvalid),
    .awready      (awready),
    .wdata        (wdata),
    .wstrb        (wstrb),
    .wvalid       (wvalid),
    .wready       (wready),
    .bresp        (bresp),
    .bvalid       (bvalid),
    .bready       (bready),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  // FIFO (first-word-fall-through) and AXI slave model
  always @(posedge clk) begin
    if (rst) begin
      rd_ptr = 0;
      stall_left = 0;
      aw_seen = 0;
      w_seen = 0;
      b_count = 0;
      aw_cnt <= 0;
      w_cnt <= 0;
      bvalid <= 1'b0;
      bresp <= RESP_OKAY;
    end else begin
      if (fifo_rd_en && !fifo_empty) rd_ptr++;
      else if (stall_left > 0) stall_left--;
      if (awvalid && awready) begin
        aw_cnt <= 0;
        aw_seen = 1;
      end else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) begin
        w_cnt <= 0;
        w_seen = 1;
      end else if (wvalid) w_cnt <= w_cnt + 1;
      if (bvalid && bready) begin
        bvalid <= 1'b0;
        if (b_count == stall_beat) stall_left = stall_len;
        b_count++;
      end else if (aw_seen && w_seen && !bvalid) begin
        bvalid <= 1'b1;
        bresp <= (b_count == err_beat) ? RESP_SLVERR
                                       : RESP_OKAY;
        aw_seen = 0;
        w_seen = 0;
      end
    end
    fifo_empty <= (rd_ptr >= fifo_cnt) || (stall_left > 0);
    fifo_rd_data <= fifo_mem[rd_ptr];
  end

  // monitor: capture AW/W handshakes, compare with scoreboard
  bit aw_got, w_got, aw_hold, w_hold;
  logic [31:0] cap_a, cap_d, hold_a, hold_d;
  logic [3:0]  cap_s, hold_s;

  always @(negedge clk) begin
    if (rst) begin
      aw_got = 0;
      w_got = 0;
      aw_hold = 0;
      w_hold = 0;
    end else begin
      if (aw_hold) begin
        check("aw_held_valid", 64'(awvalid), 64'd1);
        check("aw_held_addr", 64'(awaddr), 64'(hold_a));
      end
      if (w_hold) begin
        check("w_held_valid", 64'(wvalid), 64'd1);
        check("w_held_data", 64'(wdata), 64'(hold_d));
        check("w_held_strb", 64'(wstrb), 64'(hold_s));
      end
      aw_hold = awvalid && !awready;
      w_hold = wvalid && !wready;
      hold_a = awaddr;
      hold_d = wdata;
      hold_s = wstrb;
      if (awvalid && awready) begin
        aw_got = 1;
        cap_a = awaddr;
      end
      if (wvalid && wready) begin
        w_got = 1;
        cap_d = wdata;
        cap_s = wstrb;
      end
      if (aw_got && w_got) begin
        if (exp_rd < exp_q.size()) begin
          check("beat_addr", 64'(cap_a), 64'(exp_q[exp_rd].a));
          check("beat_data", 64'(cap_d), 64'(exp_q[exp_rd].d));
          check("beat_strb", 64'(cap_s), 64'(exp_q[exp_rd].s));
          exp_rd++;
        end else begin
          check("unexpected_beat", 64'd1, 64'd0);
        end
        aw_got = 0;
        w_got = 0;
      end
      if (stall_left > 0)
        check("stall_quiet",
              64'({awvalid, wvalid, fifo_rd_en}), 64'd0);
    end
  end

  task automatic load(input logic [31:0] w);
    fifo_mem[fifo_cnt] = w;
    fifo_cnt++;
  endtask

  task automatic exp_beat(input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s);
    beat_t b;
    b.a = a;
    b.d = d;
    b.s = s;
    exp_q.push_back(b);
  endtask

  task automatic start(input logic [31:0] dest,
                       input logic [4:0] len);
    @(negedge clk);
    dest_address = dest;
    length = len;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic run(input string name,
                     input logic [31:0] dest,
                     input logic [4:0] len,
                     input int exp_pops,
                     input logic exp_err);
    int p0;
    int n;
    p0 = rd_ptr;
    start(dest, len);
    check({name, "_busy"}, 64'(busy), 64'd1);
    check({name, "_err_clr"}, 64'(error), 64'd0);
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_idle"}, 64'(busy), 64'd0);
    check({name, "_pops"}, 64'(rd_ptr - p0), 64'(exp_pops));
    check({name, "_error"}, 64'(error), 64'(exp_err));
    check({name, "_beats"}, 64'(exp_rd), 64'(exp_q.size()));
    @(negedge clk);
    check({name, "_pulse"}, 64'(done), 64'd0);
    check({name, "_err_hold"}, 64'(error), 64'(exp_err));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_ctrl",
          64'({awvalid, wvalid, bready, fifo_rd_en,
               busy, done, error}), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_awaddr", 64'({awaddr, wstrb}), 64'd0);
    rst = 1'b0;

    load(32'h44332211);
    load(32'h88776655);
    exp_beat(32'h1000, 32'h44332211, 4'hF);
    exp_beat(32'h1004, 32'h88776655, 4'hF);
    run("aligned", 32'h1000, 5'd8, 2, 1'b0);

    load(32'h44332211);
    exp_beat(32'h1000, 32'h33221100, 4'hE);
    exp_beat(32'h1004, 32'h00000044, 4'h1);
    run("off1", 32'h1001, 5'd4, 1, 1'b0);

    load(32'h000000AB);
    exp_beat(32'h2000, 32'hAB000000, 4'h8);
    run("off3", 32'h2003, 5'd1, 1, 1'b0);

    aw_delay = 3;
    stall_beat = b_count;
    stall_len = 5;
    load(32'h44332211);
    load(32'h88776655);
    exp_beat(32'h1000, 32'h44332211, 4'hF);
    exp_beat(32'h1004, 32'h88776655, 4'hF);
    run("stall", 32'h1000, 5'd8, 2, 1'b0);
    aw_delay = 0;
    stall_beat = -1;

    err_beat = b_count;
    load(32'h44332211);
    load(32'h88776655);
    exp_beat(32'h1000, 32'h44332211, 4'hF);
    exp_beat(32'h1004, 32'h88776655, 4'hF);
    run("slverr", 32'h1000, 5'd8, 2, 1'b1);
    err_beat = -1;

    load(32'h000000CD);
    exp_beat(32'h2000, 32'hCD000000, 4'h8);
    run("clr_err", 32'h2003, 5'd1, 1, 1'b0);

    start(32'h3000, 5'd0);
    check("l0_busy", 64'(busy), 64'd1);
    check("l0_early", 64'(done), 64'd0);
    check("l0_quiet", 64'({awvalid, fifo_rd_en}), 64'd0);
    @(negedge clk);
    check("l0_done", 64'(done), 64'd1);
    check("l0_idle", 64'(busy), 64'd0);
    check("l0_quiet2", 64'({awvalid, fifo_rd_en}), 64'd0);
    @(negedge clk);
    check("l0_pulse", 64'(done), 64'd0);

    aw_delay = 10;
    load(32'h44332211);
    load(32'h88776655);
    start(32'h1000, 5'd8);
    n = 0;
    while (!awvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_in_issue", 64'(awvalid), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_ctrl",
          64'({awvalid, wvalid, bready, fifo_rd_en,
               busy, done, error}), 64'd0);
    check("rst_mid_data", 64'({awaddr, wdata}), 64'd0);
    check("rst_mid_strb", 64'(wstrb), 64'd0);
    fifo_cnt = 0;
    aw_delay = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    load(32'h000000AB);
    exp_beat(32'h2000, 32'hAB000000, 4'h8);
    run("after_rst", 32'h2003, 5'd1, 1, 1'b0);

    repeat (3) @(negedge clk);
    check("all_beats_seen", 64'(exp_rd), 64'(exp_q.size()));
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
